// File: rtl/bus_master_pkg.sv
// Shared types for the bus master command queue.
// Command layout is width-dependent, so it is built inside bus_master_queue.
package bus_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/bus_master_queue_sync_fifo.sv
// Generic DEPTH-entry synchronous FIFO, power-of-two depth, write-through-free.
// Zero-latency dout (head of queue); push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle never frees space for a push when full.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read once level says they were written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/bus_master_queue.sv
// Queued single-outstanding bus master: cmd -> FIFO -> req/ack bus -> response, with timeout.
// Req rises one edge after a push into an empty queue; cmd_ready drops only when the FIFO is full.
module bus_master_queue
    import bus_master_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [ADDR_W-1:0]        cmd_addr_i,
    input  logic [DATA_W-1:0]        cmd_wdata_i,
    output logic                     bus_req_o,
    output logic                     bus_write_o,
    output logic [ADDR_W-1:0]        bus_addr_o,
    output logic [DATA_W-1:0]        bus_wdata_o,
    input  logic                     bus_ack_i,
    input  logic [DATA_W-1:0]        bus_rdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DATA_W-1:0]        rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t   fifo_din, fifo_dout;
    logic   fifo_full, fifo_empty, fifo_pop, fifo_push;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_write_q, bus_write_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    assign cmd_ready_o = !fifo_full;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign fifo_din    = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bus_req_d   = bus_req_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_write_d = fifo_dout.write;
                    bus_addr_d  = fifo_dout.addr;
                    bus_wdata_d = fifo_dout.wdata;
                    timer_d     = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // An ack arriving on the final timer edge still counts as success.
                if (bus_ack_i) begin
                    bus_req_d   = 1'b0;
                    rsp_rdata_d = bus_write_q ? '0 : bus_rdata_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timer_q == TMR_LAST) begin
                    bus_req_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bus_req_q   <= bus_req_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_write_o = bus_write_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_bus_master_queue.sv
// Directed bench for bus_master_queue: default instance plus a wide/deep instance with a scoreboard.
module tb_bus_master_queue;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default-parameter instance
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       bus_req, bus_write, bus_ack;
    logic [7:0] bus_addr, bus_wdata, bus_rdata;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_rdata;
    logic [2:0] level;

    bus_master_queue u_dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .bus_req_o(bus_req), .bus_write_o(bus_write), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .level_o(level)
    );

    // Wide/deep instance
    logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [15:0] b_cmd_addr;
    logic [31:0] b_cmd_wdata;
    logic        b_bus_req, b_bus_write, b_bus_ack;
    logic [15:0] b_bus_addr;
    logic [31:0] b_bus_wdata, b_bus_rdata;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [3:0]  b_level;

    bus_master_queue #(.ADDR_W(16), .DATA_W(32), .DEPTH(8), .TIMEOUT(16)) u_dut_b (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_write_i(b_cmd_write),
        .cmd_addr_i(b_cmd_addr), .cmd_wdata_i(b_cmd_wdata),
        .bus_req_o(b_bus_req), .bus_write_o(b_bus_write), .bus_addr_o(b_bus_addr),
        .bus_wdata_o(b_bus_wdata), .bus_ack_i(b_bus_ack), .bus_rdata_i(b_bus_rdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .rsp_err_o(b_rsp_err), .level_o(b_level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         ack_dly;    // REQ cycle index carrying ack; -1 = slave silent
        logic [7:0] slv_rdata;
        int         exp_edges;  // edges spent in REQ
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        bus_rdata = v.slv_rdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!bus_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_req", idx), bus_req, 1);
        chk($sformatf("v%0d_addr", idx), bus_addr, v.addr);
        chk($sformatf("v%0d_write", idx), bus_write, v.write);
        chk($sformatf("v%0d_wdata", idx), bus_wdata, v.wdata);
        n = 0;
        while (bus_req && n < 40) begin
            bus_ack = (n == v.ack_dly);
            @(negedge clk);
            n++;
        end
        bus_ack = 1'b0;
        chk($sformatf("v%0d_req_edges", idx), n, v.exp_edges);
        chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
        chk($sformatf("v%0d_rsp_err", idx), rsp_err, v.exp_err);
        chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_clear", idx), rsp_valid, 0);
    endtask

    task automatic serve(input logic [7:0] exp_addr, input string name);
        int n;
        n = 0;
        while (!bus_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_req"}, bus_req, 1);
        chk({name, "_addr"}, bus_addr, exp_addr);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk({name, "_rsp_valid"}, rsp_valid, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, "_rsp_clear"}, rsp_valid, 0);
        chk({name, "_idle_gap"}, bus_req, 0);
    endtask

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
    } bcmd_t;

    bcmd_t       cq[$];
    logic [31:0] rq[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int seen;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        bus_ack = 0; bus_rdata = 0; rsp_ready = 0;
        b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_wdata = 0;
        b_bus_ack = 0; b_bus_rdata = 0; b_rsp_ready = 0;

        vecs[0] = '{1'b1, 8'h12, 8'hAA,  1, 8'h77,  2, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h34, 8'h00,  0, 8'h5C,  1, 1'b0, 8'h5C};
        vecs[2] = '{1'b0, 8'h56, 8'h00, -1, 8'h99, 16, 1'b1, 8'h00};
        vecs[3] = '{1'b0, 8'h78, 8'h00, 15, 8'hC3, 16, 1'b0, 8'hC3};
        vecs[4] = '{1'b1, 8'hFF, 8'h01, -1, 8'h42, 16, 1'b1, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 14, 8'hFF, 15, 1'b0, 8'hFF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_level", level, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_b_level", b_level, 0);
        chk("rst_b_bus_req", b_bus_req, 0);
        reset = 1'b0;

        // Push-to-request latency and write response
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h12; cmd_wdata = 8'hAA; bus_rdata = 8'h66;
        @(negedge clk);
        cmd_valid = 0;
        chk("lat_edgeN_req", bus_req, 0);
        chk("lat_edgeN_level", level, 1);
        @(negedge clk);
        chk("lat_edgeN1_req", bus_req, 1);
        chk("lat_edgeN1_level", level, 0);
        chk("lat_addr", bus_addr, 8'h12);
        chk("lat_wdata", bus_wdata, 8'hAA);
        @(negedge clk);
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("wr_req_fall", bus_req, 0);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 8'h00);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("wr_rsp_clear", rsp_valid, 0);

        // Read with response stalled; ack outside REQ must be ignored
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h34;
        @(negedge clk);
        cmd_valid = 0;
        @(negedge clk);
        chk("rd_req", bus_req, 1);
        bus_ack = 1; bus_rdata = 8'h5C;
        @(negedge clk);
        bus_rdata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_valid", i), rsp_valid, 1);
            chk($sformatf("stall%0d_rdata", i), rsp_rdata, 8'h5C);
            chk($sformatf("stall%0d_err", i), rsp_err, 0);
            @(negedge clk);
        end
        bus_ack = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("stall_release", rsp_valid, 0);
        bus_ack = 1;
        repeat (2) @(negedge clk);
        bus_ack = 0;
        chk("idle_ack_no_rsp", rsp_valid, 0);
        chk("idle_ack_no_req", bus_req, 0);

        // Table of transactions: success, delayed ack, timeout, ack on the last timer edge
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Fill to DEPTH with a stalled slave
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h40 + 8'(i);
            @(negedge clk);
        end
        cmd_addr = 8'h45;
        chk("fill_level", level, 4);
        chk("fill_ready", cmd_ready, 0);
        chk("fill_req", bus_req, 1);
        chk("fill_head_addr", bus_addr, 8'h40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fill_hold%0d_level", i), level, 4);
            chk($sformatf("fill_hold%0d_ready", i), cmd_ready, 0);
        end
        bus_ack = 1;
        @(negedge clk);
        bus_ack = 0;
        chk("fill_rsp_valid", rsp_valid, 1);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("fill_rsp_clear", rsp_valid, 0);
        chk("fill_still_full", level, 4);
        @(negedge clk);
        chk("fill_pop_no_push", level, 3);
        chk("fill_next_addr", bus_addr, 8'h41);
        chk("fill_ready_again", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
        chk("fill_sixth_pushed", level, 4);
        for (int i = 1; i <= 5; i++) serve(8'h40 + 8'(i), $sformatf("drain%0d", i));
        chk("drain_level", level, 0);

        // Reset while a request is outstanding and two commands are queued
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h60 + 8'(i); cmd_wdata = 8'h11;
            @(negedge clk);
        end
        cmd_valid = 0;
        chk("mid_level", level, 2);
        chk("mid_req", bus_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_async_req", bus_req, 0);
        chk("mid_async_level", level, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || bus_req) seen++;
        end
        chk("mid_no_activity", seen, 0);
        run_vec(vecs[1], 10);

        // Wide/deep instance against a scoreboard slave
        fork
            begin : drv
                for (int i = 0; i < 20; i++) begin
                    int g;
                    @(negedge clk);
                    b_cmd_valid = 1;
                    b_cmd_write = 1'($urandom_range(0, 1));
                    b_cmd_addr  = 16'($urandom);
                    b_cmd_wdata = 32'($urandom);
                    g = 0;
                    while (!b_cmd_ready && g < 500) begin
                        @(negedge clk);
                        g++;
                    end
                    cq.push_back('{b_cmd_write, b_cmd_addr, b_cmd_wdata});
                    @(negedge clk);
                    b_cmd_valid = 0;
                end
            end
            begin : slv
                for (int i = 0; i < 20; i++) begin
                    int n;
                    bcmd_t e;
                    logic [31:0] rd;
                    n = 0;
                    while (!b_bus_req && n < 500) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("b_req_seen", b_bus_req, 1);
                    if (!b_bus_req || cq.size() == 0) break;
                    e = cq.pop_front();
                    chk($sformatf("b%0d_addr", i), b_bus_addr, e.a);
                    chk($sformatf("b%0d_write", i), b_bus_write, e.w);
                    chk($sformatf("b%0d_wdata", i), b_bus_wdata, e.d);
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    rd = 32'($urandom);
                    b_bus_rdata = rd;
                    b_bus_ack = 1;
                    rq.push_back(e.w ? 32'h0 : rd);
                    @(negedge clk);
                    b_bus_ack = 0;
                end
            end
            begin : mon
                for (int i = 0; i < 20; i++) begin
                    int n;
                    n = 0;
                    while (!b_rsp_valid && n < 500) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("b_rsp_seen", b_rsp_valid, 1);
                    if (!b_rsp_valid || rq.size() == 0) break;
                    chk($sformatf("b%0d_rsp_rdata", i), b_rsp_rdata, rq.pop_front());
                    chk($sformatf("b%0d_rsp_err", i), b_rsp_err, 0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    b_rsp_ready = 1;
                    @(negedge clk);
                    b_rsp_ready = 0;
                end
            end
        join
        @(negedge clk);
        chk("b_final_level", b_level, 0);
        chk("b_final_cq", cq.size(), 0);
        chk("b_final_rq", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
